// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, LSB first; SERIAL_SUB_OVF_EN adds the OVF port
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             valid,
  input  logic             ack
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             br_d;
  logic             diff_bit;
  logic             last_bit;
  logic             bout_q;
  logic             valid_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  // Full-subtractor cell on the current LSBs plus the running borrow
  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_d    = (res_q >> 1) | (WIDTH'(diff_bit) << (WIDTH - 1));
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM with operand/result shifting and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            br_q    <= Bin;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            // br_q here is the borrow into the MSB; br_d is the borrow out
            d_q     <= res_d;
            bout_q  <= br_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= br_q ^ br_d;
`endif
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = (state_q == S_IDLE);
  assign valid = valid_q;
  assign D     = d_q;
  assign Bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign OVF   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         ready;
  logic [W-1:0] D;
  logic         Bout;
  logic         valid;
  logic         ack;
`ifdef SERIAL_SUB_OVF_EN
  logic         OVF;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .ready (ready),
    .D     (D),
    .Bout  (Bout),
    .valid (valid),
    .ack   (ack)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic logic [W-1:0] ref_d(input int a, input int b, input int bi);
    int r;
    r = a - b - bi;
    return r[W-1:0];
  endfunction

  function automatic logic ref_bout(input int a, input int b, input int bi);
    return (a < b + bi);
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int bi);
    int sa, sb, r;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    r  = sa - sb - bi;
    return (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
  endfunction

  // Run one operation from IDLE: optional junk start during RUN, hold DONE for hold cycles
  task automatic run_op(input int a, input int b, input int bi, input bit junk, input int hold,
                        input string tag);
    int           n;
    logic [W-1:0] ed;
    logic         eb;
    ed = ref_d(a, b, bi);
    eb = ref_bout(a, b, bi);
    check({tag, ".ready_pre"}, 32'(ready), 32'd1);
    start = 1'b1;
    A     = W'(a);
    B     = W'(b);
    Bin   = 1'(bi);
    @(negedge clk);
    // inputs after acceptance must not matter
    start = junk;
    A     = junk ? '1 : W'($urandom);
    B     = junk ? '0 : W'($urandom);
    Bin   = 1'($urandom);
    ack   = 1'($urandom);
    check({tag, ".ready_run"}, 32'(ready), 32'd0);
    n = 0;
    while (!valid && n < 50) begin
      @(negedge clk);
      n++;
      if (n == W - 1) begin
        start = 1'b0;
        ack   = 1'b0;
      end
    end
    start = 1'b0;
    ack   = 1'b0;
    check({tag, ".latency"}, 32'(n), 32'(W));
    check({tag, ".D"}, 32'(D), 32'(ed));
    check({tag, ".Bout"}, 32'(Bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, ".OVF"}, 32'(OVF), 32'(ref_ovf(a, b, bi)));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold"}, {23'd0, valid, D, Bout}, {23'd0, 1'b1, ed, eb});
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({tag, ".ready_post"}, 32'(ready), 32'd1);
    check({tag, ".valid_post"}, 32'(valid), 32'd0);
    check({tag, ".D_kept"}, 32'(D), 32'(ed));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    A     = 8'hAA;
    B     = 8'h55;
    Bin   = 1'b1;
    ack   = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst.ready", 32'(ready), 32'd1);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.D", 32'(D), 32'd0);
    check("rst.Bout", 32'(Bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst.OVF", 32'(OVF), 32'd0);
`endif
    @(negedge clk);
    check("rst.no_op", 32'(ready), 32'd1);

    run_op(8'h5A, 8'h21, 0, 1'b0, 0, "t2");
    run_op(8'h00, 8'h01, 0, 1'b0, 0, "t3a");
    run_op(8'h10, 8'h0F, 1, 1'b0, 0, "t3b");
    run_op(8'h00, 8'h00, 1, 1'b0, 0, "t3c");
    run_op(8'h33, 8'h12, 0, 1'b1, 5, "t4");
    run_op(8'hC4, 8'h09, 1, 1'b0, 1, "t4b");

    // reset during the 3rd RUN cycle
    start = 1'b1;
    A     = 8'h80;
    B     = 8'h01;
    Bin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5.ready", 32'(ready), 32'd1);
    check("t5.valid", 32'(valid), 32'd0);
    check("t5.D", 32'(D), 32'd0);
    check("t5.Bout", 32'(Bout), 32'd0);
    repeat (W + 2) @(negedge clk);
    check("t5.no_resume", 32'(valid), 32'd0);
    run_op(8'h80, 8'h01, 0, 1'b0, 0, "t5r");

`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 0, 1'b0, 0, "t6a");
    run_op(8'h05, 8'h03, 0, 1'b0, 0, "t6b");
    run_op(8'h7F, 8'hFF, 0, 1'b0, 0, "t6c");
`endif

    for (int k = 0; k < 40; k++) begin
      run_op(int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)),
             1'($urandom), int'($urandom_range(3)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: D = A - B - Bin over WIDTH-bit operands.
- One full-subtractor cell, a registered borrow, and shift registers handle one bit per clock, LSB first.
- Start/ready request and valid/ack response handshakes.
- Pairs with the combinational full-adder cell as the subtract direction of the arithmetic datapath, for area-constrained sequential use.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high; one clock; reset is synchronous and active-high
start  input  1  request; sampled only when ready=1
A  input  WIDTH  minuend; captured on accepted start
B  input  WIDTH  subtrahend; captured on accepted start
Bin  input  1  borrow-in; captured on accepted start
ready  output  1  1 in IDLE only (combinational from state)
D  output  WIDTH  difference, registered
Bout  output  1  borrow-out of MSB, registered
valid  output  1  1 in DONE only
ack  input  1  consumer accepts result when valid=1
OVF  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, borrow reg=0, bit counter=0, operand and result shift regs=0.
  - D=0, Bout=0, valid=0, ready=1 (and OVF=0 when enabled).
  - rst overrides every other input on the same edge.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch A, B, Bin; clear counter; go to RUN.
  - start=0: stay in IDLE.
- RUN (ready=0, valid=0): each edge processes bit i = counter.
  - Difference bit: d = a0 ^ b0 ^ br.
  - Next borrow: br' = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the result register at the MSB end (shift right); operand regs shift right; counter += 1.
  - On the edge where counter reaches WIDTH-1 → DONE, with:
    - D = full result
    - Bout = final br'
    - valid rising after that edge.
- Latency: accept edge at k → valid=1 after edge k+WIDTH (exactly WIDTH clocks of RUN).
  - WIDTH=1: one RUN cycle.
- DONE:
  - valid=1; D/Bout/OVF held stable.
  - Edge with ack=1 → IDLE; ready=1 on the following cycle.
  - ack=0 holds DONE indefinitely.
- start while ready=0 (RUN or DONE) is ignored; it is not queued.
- ack outside DONE is ignored.
- Throughput: at most one result per WIDTH+2 cycles.
- D/Bout keep the last result after returning to IDLE, until the next DONE entry or reset.
- Arithmetic is unsigned modulo 2^WIDTH:
  - Bout=1 iff A < B + Bin (unsigned, evaluated as integers).
  - Example: 0 - 0 - 1 gives D=all-ones, Bout=1.
- Input changes on A/B/Bin after acceptance have no effect on the running operation.
- Reset mid-RUN or in DONE aborts the operation; no partial result is exposed; all outputs take reset values.
- Counter width = clog2(WIDTH) with a minimum of 1 bit; no wrap occurs inside one operation.

Optional Feature:
SERIAL_SUB_OVF_EN
- Defined:
  - OVF port exists; OVF = (borrow into MSB) XOR (borrow out of MSB), registered with D on DONE entry.
  - Signed two's-complement overflow of A - B - Bin; 0 after reset; held with D.
- Undefined: no OVF port and no associated logic.
- All other behaviour is identical in both builds.

Test Plan (WIDTH=8):
1. rst=1 for 2 cycles with start=1 → after release: ready=1, valid=0, D=0x00, Bout=0; no operation started.
2. A=0x5A, B=0x21, Bin=0, start for 1 cycle → valid=1 exactly 8 clocks after the accept edge; D=0x39, Bout=0; ack → ready=1 next cycle.
3. A=0x00, B=0x01, Bin=0 → D=0xFF, Bout=1. Then A=0x10, B=0x0F, Bin=1 → D=0x00, Bout=0.
4. Handshake and ignore rules:
   - During RUN, drive start=1 with A=0xFF, B=0x00 → ignored; result matches the original operands.
   - Hold ack=0 for 5 cycles in DONE → valid, D, Bout stable.
   - Pulse ack, then start on the next cycle → new operation accepted.
5. Assert rst on the 3rd RUN cycle of A=0x80, B=0x01 → next cycle: IDLE, valid=0, D=0x00, Bout=0. Then rerun the same operands → D=0x7F, Bout=0.
6. With SERIAL_SUB_OVF_EN:
   - A=0x80, B=0x01, Bin=0 → OVF=1.
   - A=0x05, B=0x03 → OVF=0.
   - A=0x7F, B=0xFF → D=0x80, OVF=1, Bout=1.
